// File: rtl/trapezoid_pkg.sv
// rtl/trapezoid_pkg.sv - shared FSM encoding and derived widths for the trapezoid rasteriser
package trapezoid_pkg;

    // Edge accumulators and slopes carry two guard bits above the fixed-point coordinate.
    function automatic int acc_w(input int w, input int frac);
        return w + frac + 2;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DIV  = 3'd2,
        ST_SPAN = 3'd3,
        ST_PIX  = 3'd4,
        ST_NEXT = 3'd5
    } state_e;

endpackage

// File: rtl/trap_divider.sv
// rtl/trap_divider.sv - signed restoring divider, quotient truncated toward zero, fixed latency W+FRAC+1
module trap_divider
    import trapezoid_pkg::*;
#(
    parameter int W    = 8,
    parameter int FRAC = 10
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic signed [acc_w(W, FRAC)-1:0]  num_i,
    input  logic        [W-1:0]               den_i,
    output logic                              done_o,
    output logic signed [acc_w(W, FRAC)-1:0]  quo_o
);

    localparam int ACC_W = acc_w(W, FRAC);
    localparam int N     = W + FRAC;
    localparam int CW    = $clog2(N + 1);

    logic                    run_q;
    logic                    neg_q;
    logic                    done_q;
    logic [CW-1:0]           cnt_q;
    logic [N-1:0]            dq_q;
    logic [W-1:0]            rem_q;
    logic [W-1:0]            den_q;
    logic signed [ACC_W-1:0] quo_q;

    logic signed [ACC_W-1:0] mag_d;
    logic signed [ACC_W-1:0] q_ext_d;
    logic [W:0]              r_sh_d;
    logic [W:0]              r_diff_d;
    logic                    ge_d;

    // Divide magnitudes and restore the sign at the end, which gives truncation toward zero.
    assign mag_d    = num_i[ACC_W-1] ? -num_i : num_i;
    assign r_sh_d   = {rem_q, dq_q[N-1]};
    assign r_diff_d = r_sh_d - {1'b0, den_q};
    assign ge_d     = (r_sh_d >= {1'b0, den_q});
    assign q_ext_d  = signed'({2'b00, dq_q});

    // One quotient bit per cycle for N cycles, then one cycle to apply the sign and flag done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            dq_q   <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                run_q <= 1'b1;
                cnt_q <= '0;
                neg_q <= num_i[ACC_W-1];
                den_q <= den_i;
                dq_q  <= mag_d[N-1:0];
                // Magnitude bits above the quotient width seed the partial remainder;
                // they are zero for in-range coordinates.
                rem_q <= {{(W-2){1'b0}}, mag_d[ACC_W-1:N]};
            end else if (run_q) begin
                if (cnt_q == CW'(N)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                    quo_q  <= neg_q ? -q_ext_d : q_ext_d;
                end else begin
                    rem_q <= ge_d ? r_diff_d[W-1:0] : r_sh_d[W-1:0];
                    dq_q  <= {dq_q[N-2:0], ge_d};
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign done_o = done_q;
    assign quo_o  = quo_q;

endmodule

// File: rtl/trapezoid_raster.sv
// rtl/trapezoid_raster.sv - flat-top/flat-bottom trapezoid scan converter emitting pixels row-major
module trapezoid_raster
    import trapezoid_pkg::*;
#(
    parameter int W    = 8,
    parameter int FRAC = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         nt,
    input  logic [W-1:0] xi,
    input  logic [W-1:0] yi,
    input  logic         oready,
    output logic         busy,
    output logic         po,
    output logic [W-1:0] xo,
    output logic [W-1:0] yo
);

    localparam int ACC_W = acc_w(W, FRAC);
    localparam logic signed [ACC_W-1:0] ROUND_F = signed'({{(ACC_W-FRAC){1'b0}}, {FRAC{1'b1}}});
    localparam logic signed [ACC_W-1:0] XMAX_F  = signed'({{(ACC_W-W){1'b0}}, {W{1'b1}}});
    localparam logic [W-1:0]            ONE_W   = W'(1);

    state_e                  state_q;
    logic [1:0]              cnt_q;
    logic [W-1:0]            x0_q, y0_q, x1_q, x2_q, y2_q, x3_q;
    logic [W-1:0]            y_q, xe_q;
    logic signed [ACC_W-1:0] xl_q, xr_q, dxl_q, dxr_q;
    logic                    busy_q, po_q;
    logic [W-1:0]            xo_q, yo_q;

    logic                    div_start_d;
    logic signed [ACC_W-1:0] num_l_d, num_r_d, quo_l, quo_r;
    logic [W-1:0]            den_d;
    logic                    done_l, done_r;
    logic signed [ACC_W-1:0] xs_sum_d, xs_fix_d, xe_fix_d;
    logic [W-1:0]            xs_d, xe_d, y_nxt_d;

    function automatic logic signed [ACC_W-1:0] to_fix(input logic [W-1:0] v);
        return signed'({2'b00, v, {FRAC{1'b0}}});
    endfunction

    function automatic logic [W-1:0] clamp_px(input logic signed [ACC_W-1:0] v);
        if (v < 0)
            return '0;
        else if (v > XMAX_F)
            return '1;
        else
            return v[W-1:0];
    endfunction

    // Slopes start on the vertex-3 cycle; x3 is taken straight from the input bus.
    assign div_start_d = (state_q == ST_LOAD) && (cnt_q == 2'd3) && (y2_q != y0_q);
    assign num_l_d     = to_fix(x2_q) - to_fix(x0_q);
    assign num_r_d     = to_fix(xi) - to_fix(x1_q);
    assign den_d       = y2_q - y0_q;

    // Span ends: left edge rounds up, right edge rounds down, both clamped to the screen.
    assign xs_sum_d = xl_q + ROUND_F;
    assign xs_fix_d = xs_sum_d >>> FRAC;
    assign xe_fix_d = xr_q >>> FRAC;
    assign xs_d     = clamp_px(xs_fix_d);
    assign xe_d     = clamp_px(xe_fix_d);
    assign y_nxt_d  = y_q + ONE_W;

    trap_divider #(.W(W), .FRAC(FRAC)) u_div_l (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (div_start_d),
        .num_i   (num_l_d),
        .den_i   (den_d),
        .done_o  (done_l),
        .quo_o   (quo_l)
    );

    trap_divider #(.W(W), .FRAC(FRAC)) u_div_r (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (div_start_d),
        .num_i   (num_r_d),
        .den_i   (den_d),
        .done_o  (done_r),
        .quo_o   (quo_r)
    );

    // Control FSM with registered pixel and busy outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            x3_q    <= '0;
            y_q     <= '0;
            xe_q    <= '0;
            xl_q    <= '0;
            xr_q    <= '0;
            dxl_q   <= '0;
            dxr_q   <= '0;
            busy_q  <= 1'b0;
            po_q    <= 1'b0;
            xo_q    <= '0;
            yo_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (nt) begin
                        x0_q    <= xi;
                        y0_q    <= yi;
                        cnt_q   <= 2'd1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q <= cnt_q + 2'd1;
                    case (cnt_q)
                        2'd1: x1_q <= xi;
                        2'd2: begin
                            x2_q <= xi;
                            y2_q <= yi;
                        end
                        default: begin
                            x3_q   <= xi;
                            busy_q <= 1'b1;
                            y_q    <= y0_q;
                            if (y2_q == y0_q) begin
                                // Single row: it is also the last row, so use the bottom edge exactly.
                                xl_q    <= to_fix(x2_q);
                                xr_q    <= to_fix(xi);
                                dxl_q   <= '0;
                                dxr_q   <= '0;
                                state_q <= ST_SPAN;
                            end else begin
                                xl_q    <= to_fix(x0_q);
                                xr_q    <= to_fix(x1_q);
                                state_q <= ST_DIV;
                            end
                        end
                    endcase
                end
                ST_DIV: begin
                    if (done_l && done_r) begin
                        dxl_q   <= quo_l;
                        dxr_q   <= quo_r;
                        state_q <= ST_SPAN;
                    end
                end
                ST_SPAN: begin
                    if (xs_d <= xe_d) begin
                        po_q    <= 1'b1;
                        xo_q    <= xs_d;
                        yo_q    <= y_q;
                        xe_q    <= xe_d;
                        state_q <= ST_PIX;
                    end else begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_PIX: begin
                    if (oready) begin
                        if (xo_q == xe_q) begin
                            po_q    <= 1'b0;
                            state_q <= ST_NEXT;
                        end else begin
                            xo_q <= xo_q + ONE_W;
                        end
                    end
                end
                ST_NEXT: begin
                    if (y_q < y2_q) begin
                        y_q <= y_nxt_d;
                        // Bottom row reloads exact endpoints so slope rounding never shows there.
                        if (y_nxt_d == y2_q) begin
                            xl_q <= to_fix(x2_q);
                            xr_q <= to_fix(x3_q);
                        end else begin
                            xl_q <= xl_q + dxl_q;
                            xr_q <= xr_q + dxr_q;
                        end
                        state_q <= ST_SPAN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign po   = po_q;
    assign xo   = xo_q;
    assign yo   = yo_q;

endmodule

// File: tb/tb_trapezoid_raster.sv
// tb/tb_trapezoid_raster.sv - scoreboard bench for trapezoid_raster
module tb_trapezoid_raster;

    localparam int W       = 8;
    localparam int FRAC    = 10;
    localparam int MAX_LAT = W + FRAC + 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         nt;
    logic         oready;
    logic [W-1:0] xi;
    logic [W-1:0] yi;
    logic         busy;
    logic         po;
    logic [W-1:0] xo;
    logic [W-1:0] yo;

    logic [2*W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trapezoid_raster #(.W(W), .FRAC(FRAC)) dut (
        .clk    (clk),
        .reset  (reset),
        .nt     (nt),
        .xi     (xi),
        .yi     (yi),
        .oready (oready),
        .busy   (busy),
        .po     (po),
        .xo     (xo),
        .yo     (yo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact rational slopes truncated toward zero, per-row ceil/floor by integer rules.
    task automatic model_push(input int x0, input int y0, input int x1,
                              input int x2, input int y2, input int x3);
        int dxl, dxr, xl, xr, xs, xe;
        dxl = 0;
        dxr = 0;
        if (y2 != y0) begin
            dxl = ((x2 - x0) * (1 << FRAC)) / (y2 - y0);
            dxr = ((x3 - x1) * (1 << FRAC)) / (y2 - y0);
        end
        xl = x0 * (1 << FRAC);
        xr = x1 * (1 << FRAC);
        for (int y = y0; y <= y2; y++) begin
            if (y == y2) begin
                xl = x2 * (1 << FRAC);
                xr = x3 * (1 << FRAC);
            end
            xs = xl / (1 << FRAC);
            if (xl > 0 && (xl % (1 << FRAC)) != 0) xs = xs + 1;
            xe = xr / (1 << FRAC);
            if (xr < 0 && (xr % (1 << FRAC)) != 0) xe = xe - 1;
            if (xs < 0) xs = 0;
            if (xs > 255) xs = 255;
            if (xe < 0) xe = 0;
            if (xe > 255) xe = 255;
            for (int x = xs; x <= xe; x++) begin
                exp_q.push_back({x[W-1:0], y[W-1:0]});
            end
            xl = xl + dxl;
            xr = xr + dxr;
        end
    endtask

    task automatic drive_trap(input string tag, input int x0, input int y0, input int x1,
                              input int x2, input int y2, input int x3);
        model_push(x0, y0, x1, x2, y2, x3);
        nt = 1'b1;
        xi = x0[W-1:0];
        yi = y0[W-1:0];
        @(posedge clk); #1;
        nt = 1'b0;
        xi = x1[W-1:0];
        yi = 8'hAA;
        @(posedge clk); #1;
        xi = x2[W-1:0];
        yi = y2[W-1:0];
        @(posedge clk); #1;
        xi = x3[W-1:0];
        yi = 8'h55;
        @(posedge clk); #1;
        xi = '0;
        yi = '0;
        chk({tag, " busy_after_v3"}, 32'(busy), 32'd1);
    endtask

    task automatic run_trap(input string tag, input int exp_n, input int max_lat,
                            input int stall_at, input int abort_at, input bit poke_nt);
        int           seen;
        int           first;
        int           stall_left;
        bit           held;
        bit           done;
        logic [W-1:0] hx;
        logic [W-1:0] hy;
        seen       = 0;
        first      = -1;
        stall_left = 3;
        held       = 1'b0;
        done       = 1'b0;
        hx         = '0;
        hy         = '0;
        for (int k = 0; k < 400 && !done; k++) begin
            nt = poke_nt && (k == 2);
            xi = nt ? 8'd200 : 8'd0;
            yi = nt ? 8'd201 : 8'd0;
            if (stall_at >= 0 && seen == stall_at && stall_left > 0 && po === 1'b1) begin
                oready = 1'b0;
                stall_left--;
            end else begin
                oready = 1'b1;
            end
            @(negedge clk);
            if (held) begin
                chk({tag, " hold_po"}, 32'(po), 32'd1);
                chk({tag, " hold_xy"}, 32'({xo, yo}), 32'({hx, hy}));
            end
            held = 1'b0;
            if (po === 1'b1) begin
                if (first < 0) begin
                    first = k;
                    checks++;
                    assert (k <= max_lat) else begin
                        errors++;
                        $error("FAIL %s first_pixel_latency: observed=%0d expected<=%0d", tag, k, max_lat);
                    end
                end
                if (oready) begin
                    if (exp_q.size() == 0)
                        chk({tag, " extra_pixel"}, 32'({xo, yo}), 32'hFFFF_FFFF);
                    else
                        chk({tag, " pixel"}, 32'({xo, yo}), 32'(exp_q.pop_front()));
                    seen++;
                    if (abort_at >= 0 && seen == abort_at) done = 1'b1;
                end else begin
                    held = 1'b1;
                    hx   = xo;
                    hy   = yo;
                end
            end
            if (abort_at < 0 && first >= 0 && busy === 1'b0) done = 1'b1;
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        nt     = 1'b0;
        oready = 1'b1;
        if (abort_at < 0) begin
            chk({tag, " pixel_count"}, 32'(seen), 32'(exp_n));
            chk({tag, " busy_end"}, 32'(busy), 32'd0);
            chk({tag, " po_end"}, 32'(po), 32'd0);
            chk({tag, " queue_empty"}, 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        nt     = 1'b0;
        xi     = '0;
        yi     = '0;
        oready = 1'b1;
        #3 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset po", 32'(po), 32'd0);
        chk("reset xo", 32'(xo), 32'd0);
        chk("reset yo", 32'(yo), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        drive_trap("rect", 10, 5, 12, 10, 6, 12);
        run_trap("rect", 6, MAX_LAT, -1, -1, 1'b1);

        drive_trap("apex", 10, 0, 10, 8, 2, 12);
        run_trap("apex", 9, MAX_LAT, -1, -1, 1'b0);

        drive_trap("frac", 0, 0, 0, 0, 3, 1);
        run_trap("frac", 5, MAX_LAT, -1, -1, 1'b0);

        drive_trap("degen", 3, 7, 5, 3, 7, 5);
        run_trap("degen", 3, 2, -1, -1, 1'b0);

        drive_trap("stall", 10, 0, 10, 8, 2, 12);
        run_trap("stall", 9, MAX_LAT, 2, -1, 1'b0);

        drive_trap("rst_mid", 10, 5, 12, 10, 6, 12);
        run_trap("rst_mid", 6, MAX_LAT, -1, 2, 1'b0);
        @(posedge clk); #1;
        chk("rst_mid po_before_reset", 32'(po), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid po_async", 32'(po), 32'd0);
        chk("rst_mid busy_async", 32'(busy), 32'd0);
        chk("rst_mid xo_async", 32'(xo), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        chk("rst_mid po_held_low", 32'(po), 32'd0);
        reset = 1'b1;
        drive_trap("after_rst", 10, 5, 12, 10, 6, 12);
        run_trap("after_rst", 6, MAX_LAT, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trapezoid_raster.md
TRAPEZOID_RASTER -- requirements
Module: trapezoid_raster

Interface
REQ-001 SHALL have parameter W, default 8, meaning coordinate width in bits (unsigned pixel coordinates 0..2^W-1).
REQ-002 SHALL have parameter FRAC, default 10, meaning fraction bits of the edge accumulators and slopes.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-005 SHALL have port nt, input, 1, meaning a new-trapezoid strobe that marks vertex 0.
REQ-006 SHALL have ports xi and yi, input, W each, meaning vertex coordinates.
REQ-007 SHALL have port oready, input, 1, meaning the downstream sink accepts the pixel presented this cycle.
REQ-008 SHALL have port busy, output, 1, meaning a trapezoid is being computed or output and no new input is accepted.
REQ-009 SHALL have port po, output, 1, meaning xo/yo hold a valid pixel.
REQ-010 SHALL have ports xo and yo, output, W each, meaning the pixel coordinate.

Function
REQ-011 SHALL accept nt only when busy=0; vertex k arrives on xi/yi at cycles nt+0..nt+3; order P0=(x0,y0) top-left, P1=(x1,y0) top-right, P2=(x2,y2) bottom-left, P3=(x3,y2) bottom-right; y2>=y0; y1/y3 ignored.
REQ-012 SHALL assert busy from the cycle after vertex 3 is captured until the cycle after the last pixel handshake.
REQ-013 SHALL use FSM states IDLE, LOAD (vertices 1..3), DIV, SPAN, PIX, NEXT: IDLE->LOAD on nt; LOAD->DIV after vertex 3; DIV->SPAN when divider done; SPAN->PIX if span non-empty, else ->NEXT; PIX->NEXT after handshake of x=xe; NEXT->SPAN if y<y2, else ->IDLE.
REQ-014 SHALL compute signed slopes dxl=trunc0((x2-x0)*2^FRAC/(y2-y0)) and dxr=trunc0((x3-x1)*2^FRAC/(y2-y0)), with W+FRAC+2-bit signed intermediates.
REQ-015 SHALL skip DIV and render scanline y0 only when y2==y0.
REQ-016 SHALL initialise xl=x0<<FRAC and xr=x1<<FRAC, and add dxl/dxr in NEXT.
REQ-017 SHALL load xl=x2<<FRAC and xr=x3<<FRAC exactly for the last scanline y==y2, so accumulation error does not reach the final row.
REQ-018 SHALL compute the span per scanline as xs=ceil(xl), xe=floor(xr), each clamped to [0, 2^W-1]; xs>xe yields zero pixels on that row.
REQ-019 SHALL emit pixels row-major, y ascending, x ascending, at one pixel per cycle while oready=1.
REQ-020 SHALL, when po=1 and oready=0, hold xo, yo and po stable; no pixel is dropped or duplicated.
REQ-021 SHALL present the first pixel no later than W+FRAC+6 cycles after vertex 3.
REQ-022 SHALL ignore nt while busy=1.

Reset
REQ-023 SHALL, on reset low, asynchronously force busy=0, po=0, xo=0, yo=0 and FSM=IDLE, and clear the accumulators and the divider.
REQ-024 SHALL abandon a trapezoid on reset mid-operation with no further po; nt is accepted in the first clock after reset releases.

Structure
REQ-025 SHALL hold FSM state encoding and derived widths (ACC_W=W+FRAC+2) in shared package trapezoid_pkg.
REQ-026 SHALL use one sub-module trap_divider: a signed restoring divider with start/done handshake and fixed latency of W+FRAC+1 cycles; two instances run dxl and dxr in parallel.

Verification
REQ-027 SHALL cover rectangle W=8/FRAC=10: (10,5),(12,5),(10,6),(12,6) -> 6 pixels (10..12,5),(10..12,6), then busy=0.
REQ-028 SHALL cover apex (10,0),(10,0),(8,2),(12,2) -> rows 10; 9..11; 8..12; 9 pixels total.
REQ-029 SHALL cover fractional slope (0,0),(0,0),(0,3),(1,3) -> dxr=341; rows 0..2 give x=0 only; row 3 gives x=0..1; 5 pixels.
REQ-030 SHALL cover degenerate y2==y0: (3,7),(5,7),(3,7),(5,7) -> pixels (3..5,7), with DIV skipped.
REQ-031 SHALL cover backpressure: oready=0 for 3 cycles mid-row of REQ-028 -> xo/yo held, sequence identical, count 9.
REQ-032 SHALL cover reset asserted during PIX -> po=0 and busy=0 immediately; the next nt renders REQ-027 correctly.
